// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial data memory controller.
// Holds bus widths, the IO region tag and the FSM encoding.
package mem_ctrl_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int REG_W      = 32;

  localparam logic [1:0] IO_REGION = 2'b11;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_state_t;

  function automatic logic [2:0] len_decode(
    input logic [2:0] len
  );
    unique case (1'b1)
      len == 3'd1: return 3'd1;
      len == 3'd2: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(
    input logic [REG_W-1:0] data,
    input logic [1:0]       idx
  );
    logic [REG_W-1:0] sh;
    sh = data >> {idx, 3'b000};
    return sh[7:0];
  endfunction

  // lo holds bytes 0..2 already captured; last is the final byte.
  function automatic logic [REG_W-1:0] load_extend(
    input logic [2:0]  len,
    input logic        sgn,
    input logic [23:0] lo,
    input logic [7:0]  last
  );
    unique case (1'b1)
      len == 3'd1: return {{24{sgn & last[7]}}, last};
      len == 3'd2: return {{16{sgn & last[7]}}, last, lo[7:0]};
      default:     return {last, lo};
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Data-cache side memory controller: serialises 1/2/4-byte loads
// and stores over a byte-wide RAM/IO port, one request at a time.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_i,
  input  logic              sign_i,
  input  logic [2:0]        r_len_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic [REG_W-1:0]  r_data_o,
  output logic              r_done_o,
  output logic              r_wait_o,
  input  logic              write_i,
  input  logic [2:0]        w_len_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [REG_W-1:0]  w_data_i,
  output logic              w_done_o,
  output logic              w_wait_o,
  input  logic [7:0]        mem_din_i,
  output logic [7:0]        mem_dout_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o,
  input  logic              io_buffer_full_i
);

  mem_state_t        state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        len_q;
  logic              sign_q;
  logic [REG_W-1:0]  wdata_q;
  logic [23:0]       rbuf;

  logic bubble;
  logic io_stall;
  logic accept_w, accept_r;
  logic rd_last, wr_last;
  logic capture;

  assign bubble   = r_done_o | w_done_o;
  assign io_stall = (addr_q[17:16] == IO_REGION) & io_buffer_full_i;
  assign capture  = (state == MEM_READ) & (cnt != 3'd0) & (cnt < len_q);

  assign r_wait_o = (state != MEM_IDLE) | bubble | write_i;
  assign w_wait_o = (state != MEM_IDLE) | bubble;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    accept_w   = 1'b0;
    accept_r   = 1'b0;
    rd_last    = 1'b0;
    wr_last    = 1'b0;
    mem_a_o    = '0;
    mem_dout_o = '0;
    mem_wr_o   = 1'b0;
    unique case (state)
      MEM_IDLE: begin
        // Writes first so a dirty write-back beats the refill.
        if (!bubble) begin
          if (write_i) begin
            accept_w = 1'b1;
            state_n  = MEM_WRITE;
            cnt_n    = 3'd0;
          end else if (read_i) begin
            accept_r = 1'b1;
            state_n  = MEM_READ;
            cnt_n    = 3'd0;
          end
        end
      end
      MEM_READ: begin
        if (cnt < len_q) begin
          mem_a_o = addr_q + ADDR_W'(cnt);
        end
        if (cnt == len_q) begin
          rd_last = 1'b1;
          state_n = MEM_IDLE;
          cnt_n   = 3'd0;
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      MEM_WRITE: begin
        mem_a_o    = addr_q + ADDR_W'(cnt);
        mem_dout_o = byte_of(wdata_q, cnt[1:0]);
        if (!io_stall) begin
          mem_wr_o = 1'b1;
          if (cnt == len_q - 3'd1) begin
            wr_last = 1'b1;
            state_n = MEM_IDLE;
            cnt_n   = 3'd0;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end
      default: begin
        state_n = MEM_IDLE;
        cnt_n   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MEM_IDLE;
      cnt      <= 3'd0;
      addr_q   <= '0;
      len_q    <= 3'd0;
      sign_q   <= 1'b0;
      wdata_q  <= '0;
      rbuf     <= '0;
      r_data_o <= '0;
      r_done_o <= 1'b0;
      w_done_o <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      r_done_o <= rd_last;
      w_done_o <= wr_last;
      if (accept_w) begin
        addr_q  <= w_addr_i;
        len_q   <= len_decode(w_len_i);
        wdata_q <= w_data_i;
      end
      if (accept_r) begin
        addr_q <= r_addr_i;
        len_q  <= len_decode(r_len_i);
        sign_q <= sign_i;
      end
      if (capture) begin
        case (cnt)
          3'd1:    rbuf[7:0]   <= mem_din_i;
          3'd2:    rbuf[15:8]  <= mem_din_i;
          3'd3:    rbuf[23:16] <= mem_din_i;
          default: ;
        endcase
      end
      if (rd_last) begin
        r_data_o <= load_extend(len_q, sign_q, rbuf, mem_din_i);
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model that returns
// read data one cycle after the address.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_i, sign_i, write_i, io_buffer_full_i;
  logic [2:0]  r_len_i, w_len_i;
  logic [31:0] r_addr_i, w_addr_i, w_data_i;
  logic [31:0] r_data_o;
  logic        r_done_o, r_wait_o, w_done_o, w_wait_o;
  logic [7:0]  mem_din_i, mem_dout_o;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;

  logic [7:0]  ram [0:4095];
  int          wr_cnt = 0;
  logic [31:0] last_wa = '0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .read_i(read_i), .sign_i(sign_i),
    .r_len_i(r_len_i), .r_addr_i(r_addr_i),
    .r_data_o(r_data_o), .r_done_o(r_done_o),
    .r_wait_o(r_wait_o),
    .write_i(write_i), .w_len_i(w_len_i),
    .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .w_done_o(w_done_o), .w_wait_o(w_wait_o),
    .mem_din_i(mem_din_i), .mem_dout_o(mem_dout_o),
    .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o),
    .io_buffer_full_i(io_buffer_full_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_o) begin
      ram[mem_a_o[11:0]] <= mem_dout_o;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_a_o;
    end
    mem_din_i <= ram[mem_a_o[11:0]];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] len,
                         input logic sg, input logic [31:0] exp,
                         input string tag);
    int n;
    bit done;
    n = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
    @(posedge clk); #1;
    read_i = 1'b1; r_addr_i = a; r_len_i = len; sign_i = sg;
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(posedge clk); #1;
      if (k < n) check({tag, "_addr"}, mem_a_o, a + k);
      if (k == 0) check({tag, "_busy"}, {r_wait_o, w_wait_o}, 2'b11);
      if (r_done_o) begin
        done = 1'b1;
        check({tag, "_lat"}, k, n + 1);
        check({tag, "_data"}, r_data_o, exp);
        read_i = 1'b0;
      end
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
    @(posedge clk); #1;
    check({tag, "_pulse"}, r_done_o, 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] len,
                          input logic [31:0] d, input int stall,
                          input string tag);
    int n;
    bit done;
    int wr0;
    logic [31:0] sh;
    n = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
    @(posedge clk); #1;
    write_i = 1'b1; w_addr_i = a; w_len_i = len; w_data_i = d;
    io_buffer_full_i = (stall > 0);
    wr0 = wr_cnt;
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(posedge clk); #1;
      if (k >= stall) io_buffer_full_i = 1'b0;
      #1;
      if (w_done_o) begin
        done = 1'b1;
        check({tag, "_lat"}, k, n + stall);
        write_i = 1'b0;
      end else if (k < stall) begin
        check({tag, "_stall_wr"}, mem_wr_o, 0);
      end else if (k - stall < n) begin
        sh = d >> (8 * (k - stall));
        check({tag, "_addr"}, mem_a_o, a + (k - stall));
        check({tag, "_byte"}, {mem_wr_o, mem_dout_o}, {1'b1, sh[7:0]});
      end
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
    check({tag, "_nwr"}, wr_cnt - wr0, n);
    @(posedge clk); #1;
    check({tag, "_pulse"}, w_done_o, 0);
  endtask

  initial begin
    int kw, kr;
    bit rdone;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h5A;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22;
    ram[12'h102] = 8'h33; ram[12'h103] = 8'h84;
    ram[12'h040] = 8'h80;
    ram[12'h050] = 8'h01; ram[12'h051] = 8'h80;
    rst = 1'b1;
    read_i = 0; sign_i = 0; write_i = 0; io_buffer_full_i = 0;
    r_len_i = 0; w_len_i = 0; r_addr_i = 0; w_addr_i = 0; w_data_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", r_data_o, 0);
    check("rst_done", {r_done_o, w_done_o}, 2'b00);
    check("rst_ram", {mem_a_o, mem_dout_o, mem_wr_o}, 41'd0);
    check("rst_wait", {r_wait_o, w_wait_o}, 2'b00);
    rst = 1'b0;

    do_read(32'h100, 3'd4, 1'b0, 32'h84332211, "word");
    do_read(32'h040, 3'd1, 1'b1, 32'hFFFFFF80, "byte_s");
    do_read(32'h040, 3'd1, 1'b0, 32'h00000080, "byte_u");
    do_read(32'h050, 3'd2, 1'b1, 32'hFFFF8001, "half_s");
    do_read(32'h050, 3'd7, 1'b1, 32'h5A5A8001, "len7");

    do_write(32'h202, 3'd2, 32'h1234BEEF, 0, "half_st");
    check("half_st_202", ram[12'h202], 8'hEF);
    check("half_st_203", ram[12'h203], 8'hBE);
    check("half_st_204", ram[12'h204], 8'h5A);

    do_write(32'h30004, 3'd1, 32'h00000077, 3, "io");
    check("io_ram", ram[12'h004], 8'h77);
    check("io_addr", last_wa, 32'h30004);

    // Simultaneous requests: write first, read after the bubble.
    @(posedge clk); #1;
    write_i = 1; w_addr_i = 32'h300; w_len_i = 3'd4;
    w_data_i = 32'hCAFEF00D;
    read_i = 1; r_addr_i = 32'h300; r_len_i = 3'd4; sign_i = 1;
    #1;
    check("sim_wait", {r_wait_o, w_wait_o}, 2'b10);
    kw = -1; kr = -1; rdone = 0;
    for (int k = 0; k < 40 && !rdone; k++) begin
      @(posedge clk); #1;
      if (k == 1) check("sim_rwait", r_wait_o, 1);
      if (w_done_o) begin kw = k; write_i = 0; end
      if (r_done_o) begin
        rdone = 1; kr = k; read_i = 0;
        check("sim_data", r_data_o, 32'hCAFEF00D);
      end
    end
    check("sim_wlat", kw, 4);
    check("sim_rlat", kr, 11);

    // Reset in the middle of a word load.
    repeat (2) @(posedge clk);
    #1;
    read_i = 1; r_addr_i = 32'h100; r_len_i = 3'd4; sign_i = 0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1;
    #1;
    check("mid_rst_ram", {mem_a_o, mem_wr_o}, 33'd0);
    check("mid_rst_out", {r_data_o, r_done_o, w_done_o}, 34'd0);
    check("mid_rst_wait", {r_wait_o, w_wait_o}, 2'b00);
    read_i = 0;
    @(posedge clk); #1;
    rst = 0;
    kr = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (r_done_o) kr++;
    end
    check("mid_rst_nodone", kr, 0);
    do_read(32'h100, 3'd4, 1'b0, 32'h84332211, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that serves the data cache's byte-length read and write requests over the single byte-wide RAM/IO port of the CPU. It sits between `cache_d` and the external RAM interface. It accepts one request at a time, sequences 1/2/4 single-byte RAM accesses, assembles and extends loads, and returns a one-cycle done pulse.

## Interface
- `ADDR_W`, 32: RAM/IO address width (matches `` `MemAddrBus ``).
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `read_i` in 1: load request, level, held until `r_done_o`.
- `sign_i` in 1: sign-extend load result (lengths 1 and 2 only).
- `r_len_i` in 3: load byte count 1/2/4; any other value is treated as 4.
- `r_addr_i` in ADDR_W: load start address.
- `r_data_o` out 32: assembled, extended load data; valid while `r_done_o` is high.
- `r_done_o` out 1: one-cycle load completion pulse.
- `r_wait_o` out 1: a load cannot be accepted this cycle.
- `write_i` in 1: store request, level, held until `w_done_o`.
- `w_len_i` in 3: store byte count 1/2/4; other values are treated as 4.
- `w_addr_i` in ADDR_W: store start address.
- `w_data_i` in 32: store data, little-endian, low bytes used.
- `w_done_o` out 1: one-cycle store completion pulse.
- `w_wait_o` out 1: a store cannot be accepted this cycle.
- `mem_din_i` in 8: RAM read byte; returns the data for the address driven in the previous cycle.
- `mem_dout_o` out 8: RAM write byte.
- `mem_a_o` out ADDR_W: RAM address.
- `mem_wr_o` out 1: 1 = write, 0 = read.
- `io_buffer_full_i` in 1: IO write buffer full; IO stores must stall.

## Operation
- **FSM states:** IDLE, READ, WRITE. A counter `cnt` (3 bits) is the byte index.
- **Acceptance in IDLE:**
  - Only when neither done output is high this cycle; this is a one-cycle bubble after every completion.
  - If `write_i` is high, latch the write fields and go to WRITE with cnt=0.
  - Otherwise, if `read_i` is high, latch the read fields and go to READ with cnt=0.
  - Writes take priority over reads (dirty write-back precedes refill).
- **READ, length N:**
  - Each cycle with cnt<N drives `mem_a_o`=addr+cnt and `mem_wr_o`=0.
  - Each cycle with cnt≥1 captures `mem_din_i` as byte cnt-1, little-endian.
  - At cnt=N the last byte is taken directly from `mem_din_i`. The result is sign/zero-extended and registered into `r_data_o`, `r_done_o`←1, and the state returns to IDLE.
- **WRITE, length N:**
  - Each cycle drives `mem_a_o`=addr+cnt, `mem_dout_o`=byte cnt of the data, and `mem_wr_o`=1.
  - At cnt=N-1 set `w_done_o`←1 and return to IDLE.
- **IO stall:** addr[17:16]==2'b11 is IO space. While in WRITE to IO space with `io_buffer_full_i`=1: `mem_wr_o`=0, cnt holds, no byte is written. The write resumes on the first cycle the input is low.
- **Extension:**
  - len 1: bits [31:8] = sign ? byte[7] : 0.
  - len 2: bits [31:16] = sign ? byte1[7] : 0.
  - len 4: `sign_i` is ignored.
- **Address arithmetic:** ADDR_W bits, wraps modulo 2^ADDR_W.
- **Wait outputs:**
  - `r_wait_o` = state≠IDLE | done bubble | `write_i`.
  - `w_wait_o` = state≠IDLE | done bubble.
- **Reset:** `rst` asserted at any time forces IDLE, cnt=0, and all outputs to 0, with no done pulse. Bytes already written by an aborted store remain in RAM.

## Timing
- All outputs are registered or decoded from the registered state. No combinational path from request inputs to RAM outputs.
- **Reset values:** `r_data_o`=0, `r_done_o`=0, `w_done_o`=0, `mem_a_o`=0, `mem_dout_o`=0, `mem_wr_o`=0. `r_wait_o`/`w_wait_o` are 0 in IDLE unless `write_i` is high.
- **Load latency:** request sampled at edge E0. Address bytes are driven in cycles E0..E0+N-1. `r_done_o` is high during the cycle following edge E0+N+1. A word load takes 5 edges after acceptance; a byte load takes 2.
- **Store latency:** `w_done_o` is high during the cycle following edge E0+N, plus any IO stall cycles.
- **Done pulses:** exactly one cycle wide. Requesters drop the request in the done cycle.
- RAM outputs are idle (`mem_a_o`=0, `mem_wr_o`=0) in IDLE.

## Structure
- `config.v` holds:
  - `` `MemAddrBus ``, `` `RegBus ``
  - the IO region constant (2'b11 at bits [17:16])
  - the FSM state encodings: `` `MemIdle ``, `` `MemRead ``, `` `MemWrite ``
- Single module; no sub-module. Byte assembly and extension are inline.

## Test plan
- **Word load:** RAM[0x100..0x103] = 11,22,33,84, read len4 @0x100 → `mem_a_o` sequence 100,101,102,103; `r_data_o`=0x84332211; `r_done_o` 1 cycle, 5 edges after acceptance.
- **Byte loads:** RAM[0x40]=0x80. Read len1 sign=1 → 0xFFFFFF80. Read len1 sign=0 → 0x00000080. Half load 0x8001 with sign=1 → 0xFFFF8001.
- **Half store:** 0x1234BEEF len2 @0x202 → cycle1 writes 0x202←EF, cycle2 writes 0x203←BE; `w_done_o` after 2 edges; RAM[0x204] untouched.
- **Simultaneous requests:** `read_i` and `write_i` asserted together → write served first with `r_wait_o`=1; read accepted after the `w_done_o` bubble; both data correct.
- **IO stall:** store len1 to 0x30004 with `io_buffer_full_i` high for 3 cycles → `mem_wr_o` stays 0 for 3 cycles; single write of the byte afterward; `w_done_o` delayed by exactly 3.
- **Reset mid-operation:** `rst` pulsed mid word-load after 2 bytes → all outputs 0 immediately; no `r_done_o`; a subsequent load of 0x100 returns 0x84332211.
